// File: rtl/lm70_spi_responder_pkg.sv
// Shared definitions for the LM70 SPI responder model.
//   state_e         : responder FSM states
//   FRAME_BITS      : bits per read frame and per configuration write
//   CMD_SHUTDOWN    : configuration low byte that enters shutdown
//   CMD_CONTINUOUS  : configuration low byte that returns to continuous conversion
//   ID_WORD_DEFAULT : frame returned while in shutdown
package lm70_spi_responder_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRead  = 2'b01,
        StWrite = 2'b10,
        StDone  = 2'b11
    } state_e;

    localparam int unsigned FRAME_BITS      = 16;
    localparam logic [4:0]  LAST_BIT        = 5'(FRAME_BITS - 1);
    localparam logic [7:0]  CMD_SHUTDOWN    = 8'hFF;
    localparam logic [7:0]  CMD_CONTINUOUS  = 8'h00;
    localparam logic [15:0] ID_WORD_DEFAULT = 16'h8100;

endpackage

// File: rtl/lm70_spi_responder_spi_in_sync.sv
// N-stage input synchronizer with rise/fall detection on the synchronized value.
//   clk, rst_n : block clock, asynchronous active-low reset
//   din        : asynchronous input pin
//   dout       : synchronized level
//   rise, fall : single-clk pulses on synchronized edges
module lm70_spi_responder_spi_in_sync #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    always_comb begin
        dout = sync_q[STAGES-1];
        rise = sync_q[STAGES-1] & ~prev_q;
        fall = ~sync_q[STAGES-1] & prev_q;
    end

endmodule

// File: rtl/lm70_spi_responder.sv
// Behavioural LM70 temperature sensor, SPI side. Shifts out a 16-bit frame on the
// controller's SCK falling edges, then accepts an optional 16-bit configuration write.
//   clk, rst_n          : block clock (>= 4x SCK), asynchronous active-low reset
//   cs_n_i, sck_i       : chip select and serial clock from the controller
//   sio_i               : SIO as driven by the controller
//   sio_o, sio_oe       : SIO data / drive enable from the responder
//   temp_i, temp_load_i : temperature (0.25 C/LSB) and its load strobe
//   shutdown_o          : current shutdown mode
//   frame_done_o        : pulse on a completed 16-bit read
//   write_done_o        : pulse on a completed 16-bit write
module lm70_spi_responder
    import lm70_spi_responder_pkg::*;
#(
    parameter logic [15:0] ID_WORD     = ID_WORD_DEFAULT,
    parameter logic [4:0]  TRAIL_BITS  = 5'b11111,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs_n_i,
    input  logic        sck_i,
    input  logic        sio_i,
    output logic        sio_o,
    output logic        sio_oe,
    input  logic [10:0] temp_i,
    input  logic        temp_load_i,
    output logic        shutdown_o,
    output logic        frame_done_o,
    output logic        write_done_o
);

    localparam int unsigned WARM_CYCLES = SYNC_STAGES + 1;
    localparam int unsigned WARM_W      = $clog2(WARM_CYCLES + 1);

    logic cs_s, cs_rise, cs_fall;
    logic sck_s, sck_rise, sck_fall;
    logic sio_s, sio_rise, sio_fall;

    lm70_spi_responder_spi_in_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (cs_n_i),
        .dout (cs_s),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    lm70_spi_responder_spi_in_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (sck_i),
        .dout (sck_s),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    lm70_spi_responder_spi_in_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sio_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (sio_i),
        .dout (sio_s),
        .rise (sio_rise),
        .fall (sio_fall)
    );

    state_e           state_q, state_d;
    logic [15:0]      tx_q;
    logic [15:0]      rx_q, rx_next;
    logic [4:0]       bit_cnt_q;
    logic [10:0]      temp_hold_q;
    logic             shutdown_q;
    logic             frame_done_q, write_done_q;
    logic [WARM_W-1:0] warm_q;
    logic             sync_ready;
    logic [15:0]      frame_word;
    logic             last_bit;
    logic             unused_sig;

    // The CS synchronizer presets to "deselected", so if CS is already low when reset
    // releases, the flush of the preset looks like a falling edge. Ignore CS edges until
    // the chain holds only real pin samples.
    assign sync_ready = (warm_q == WARM_W'(WARM_CYCLES));
    assign last_bit   = (bit_cnt_q == LAST_BIT);
    assign frame_word = shutdown_q ? ID_WORD : {temp_hold_q, TRAIL_BITS};
    assign rx_next    = {rx_q[14:0], sio_s};
    assign unused_sig = sio_rise ^ sio_fall ^ sck_s ^ rx_q[15];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; a CS rising edge overrides any SCK edge in the same clk
    always_comb begin
        state_d = state_q;
        if (cs_rise) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (cs_fall && sync_ready) state_d = StRead;
                StRead:  if (sck_fall && last_bit)  state_d = StWrite;
                StWrite: if (sck_rise && last_bit)  state_d = StDone;
                StDone:  state_d = StDone;
            endcase
        end
    end

    // Outputs
    always_comb begin
        sio_oe       = (state_q == StRead);
        sio_o        = tx_q[15];
        shutdown_o   = shutdown_q;
        frame_done_o = frame_done_q;
        write_done_o = write_done_q;
    end

    // Datapath: shift registers, bit counter, mode, pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q         <= '0;
            rx_q         <= '0;
            bit_cnt_q    <= '0;
            temp_hold_q  <= '0;
            shutdown_q   <= 1'b0;
            frame_done_q <= 1'b0;
            write_done_q <= 1'b0;
            warm_q       <= '0;
        end else begin
            frame_done_q <= 1'b0;
            write_done_q <= 1'b0;
            if (!sync_ready) begin
                warm_q <= warm_q + WARM_W'(1);
            end
            if (temp_load_i && cs_s) begin
                temp_hold_q <= temp_i;
            end
            if (cs_rise) begin
                bit_cnt_q <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (cs_fall && sync_ready) begin
                            tx_q      <= frame_word;
                            bit_cnt_q <= '0;
                        end
                    end
                    StRead: begin
                        if (sck_fall) begin
                            tx_q <= {tx_q[14:0], 1'b0};
                            if (last_bit) begin
                                bit_cnt_q    <= '0;
                                frame_done_q <= 1'b1;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                            end
                        end
                    end
                    StWrite: begin
                        if (sck_rise) begin
                            rx_q <= rx_next;
                            if (last_bit) begin
                                bit_cnt_q    <= '0;
                                write_done_q <= 1'b1;
                                if (rx_next[7:0] == CMD_SHUTDOWN) begin
                                    shutdown_q <= 1'b1;
                                end else if (rx_next[7:0] == CMD_CONTINUOUS) begin
                                    shutdown_q <= 1'b0;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                            end
                        end
                    end
                    StDone: begin
                        bit_cnt_q <= bit_cnt_q;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lm70_spi_responder.sv
// Directed bench: acts as the SPI controller and checks completed reads/writes via a
// scoreboard of expected events popped by a monitor on every DUT done pulse.
module tb_lm70_spi_responder;

    typedef struct {
        bit          is_write;
        logic [15:0] val;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        cs_n;
    logic        sck;
    logic        sio_in;
    logic        sio_o;
    logic        sio_oe;
    logic [10:0] temp;
    logic        temp_load;
    logic        shutdown;
    logic        frame_done;
    logic        write_done;

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    logic [15:0] rx_word;

    lm70_spi_responder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cs_n_i      (cs_n),
        .sck_i       (sck),
        .sio_i       (sio_in),
        .sio_o       (sio_o),
        .sio_oe      (sio_oe),
        .temp_i      (temp),
        .temp_load_i (temp_load),
        .shutdown_o  (shutdown),
        .frame_done_o(frame_done),
        .write_done_o(write_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input bit is_write, input logic [15:0] val);
        exp_t e;
        e.is_write = is_write;
        e.val      = val;
        exp_q.push_back(e);
    endtask

    task automatic cs_low();
        cs_n    = 1'b0;
        rx_word = '0;
        tick(6);
    endtask

    task automatic cs_high();
        cs_n   = 1'b1;
        sio_in = 1'b0;
        tick(8);
    endtask

    // Controller samples SIO just before each SCK rising edge
    task automatic read_bits(input int n);
        for (int i = 0; i < n; i++) begin
            rx_word = {rx_word[14:0], sio_o};
            sck = 1'b1;
            tick(4);
            sck = 1'b0;
            tick(4);
        end
    endtask

    task automatic write_bits(input logic [15:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            sio_in = w[15-i];
            tick(2);
            sck = 1'b1;
            tick(4);
            sck = 1'b0;
            tick(2);
        end
    endtask

    task automatic load_temp(input logic [10:0] v);
        temp      = v;
        temp_load = 1'b1;
        tick(1);
        temp_load = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] expect_word);
        cs_low();
        push_ev(1'b0, expect_word);
        read_bits(16);
        cs_high();
    endtask

    // Monitor: every done pulse must match the next expected event
    always @(negedge clk) begin
        if (rst_n && (frame_done || write_done)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done_pulse", {30'd0, write_done, frame_done}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (frame_done) begin
                    check("event_kind_read", {31'd0, e.is_write}, 32'd0);
                    check("read_frame", {16'd0, rx_word}, {16'd0, e.val});
                    check("oe_after_read", {31'd0, sio_oe}, 32'd0);
                end else begin
                    check("event_kind_write", {31'd0, e.is_write}, 32'd1);
                    check("write_shutdown", {31'd0, shutdown}, {31'd0, e.val[0]});
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        cs_n      = 1'b1;
        sck       = 1'b0;
        sio_in    = 1'b0;
        temp      = '0;
        temp_load = 1'b0;
        rx_word   = '0;
        tick(3);
        rst_n = 1'b1;
        tick(6);

        check("reset_sio_oe", {31'd0, sio_oe}, 32'd0);
        check("reset_sio_o", {31'd0, sio_o}, 32'd0);
        check("reset_shutdown", {31'd0, shutdown}, 32'd0);
        check("reset_frame_done", {31'd0, frame_done}, 32'd0);
        check("reset_write_done", {31'd0, write_done}, 32'd0);

        // Normal read, +50 C
        load_temp(11'h0C8);
        cs_low();
        check("oe_during_read", {31'd0, sio_oe}, 32'd1);
        push_ev(1'b0, 16'h191F);
        read_bits(16);
        cs_high();
        check("oe_idle", {31'd0, sio_oe}, 32'd0);

        // Negative temperature, -10 C
        load_temp(11'h7D8);
        do_read(16'hFB1F);

        // Enter shutdown, ID word returned, non-command byte keeps mode, back to continuous
        cs_low();
        push_ev(1'b0, 16'hFB1F);
        read_bits(16);
        push_ev(1'b1, 16'h0001);
        write_bits(16'h00FF, 16);
        cs_high();
        do_read(16'h8100);
        cs_low();
        push_ev(1'b0, 16'h8100);
        read_bits(16);
        push_ev(1'b1, 16'h0001);
        write_bits(16'h12AB, 16);
        cs_high();
        do_read(16'h8100);
        cs_low();
        push_ev(1'b0, 16'h8100);
        read_bits(16);
        push_ev(1'b1, 16'h0000);
        write_bits(16'h0000, 16);
        cs_high();
        do_read(16'hFB1F);

        // Aborted read after 7 bits: no pulse, next read intact
        cs_low();
        read_bits(7);
        cs_high();
        check("oe_after_abort_read", {31'd0, sio_oe}, 32'd0);
        do_read(16'hFB1F);

        // Aborted write after 10 bits of 00FF: mode unchanged
        cs_low();
        push_ev(1'b0, 16'hFB1F);
        read_bits(16);
        write_bits(16'h00FF, 10);
        cs_high();
        check("shutdown_after_abort_write", {31'd0, shutdown}, 32'd0);
        do_read(16'hFB1F);

        // Load while CS low is dropped; later load with CS high is taken
        cs_low();
        load_temp(11'h010);
        push_ev(1'b0, 16'hFB1F);
        read_bits(16);
        cs_high();
        do_read(16'hFB1F);
        load_temp(11'h010);
        do_read(16'h021F);

        // Reset in the middle of a read while in shutdown
        cs_low();
        push_ev(1'b0, 16'h021F);
        read_bits(16);
        push_ev(1'b1, 16'h0001);
        write_bits(16'h00FF, 16);
        cs_high();
        cs_low();
        check("oe_before_reset", {31'd0, sio_oe}, 32'd1);
        read_bits(5);
        #3 rst_n = 1'b0;
        #1;
        check("async_reset_sio_oe", {31'd0, sio_oe}, 32'd0);
        check("async_reset_shutdown", {31'd0, shutdown}, 32'd0);
        tick(3);
        #3 rst_n = 1'b1;
        tick(20);
        check("no_drive_after_reset_cs_low", {31'd0, sio_oe}, 32'd0);
        cs_high();
        do_read(16'h001F);

        tick(10);
        check("pending_events", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lm70_spi_responder.md
Name: lm70_spi_responder

Overview:
- Behavioural RTL model of the LM70 end of the temperature-monitor SPI link.
- Responds to the monitor's CS/SCK: shifts out a 16-bit temperature frame on SIO, then accepts the optional 16-bit configuration write (shutdown / continuous).
- Sits on the test board and the FPGA bench opposite the SPI controller so the controller can be exercised without silicon.
- Samples CS and SCK in its own `clk` domain.

Parameters:
- ID_WORD, 16'h8100: frame returned while in shutdown.
- TRAIL_BITS, 5'b11111: fixed value of D4..D0 in a normal read frame.
- SYNC_STAGES, 2: synchronizer depth on cs_n_i, sck_i and sio_i (minimum 2).

Ports:
- clk  input  1  block clock; must be ≥4× SCK frequency.
- rst_n  input  1  asynchronous active-low reset.
- cs_n_i  input  1  chip select from controller, active low.
- sck_i  input  1  serial clock from controller; idles low.
- sio_i  input  1  SIO as driven by the controller (write phase).
- sio_o  output  1  SIO data driven by the responder.
- sio_oe  output  1  1 = responder drives SIO.
- temp_i  input  11  two's-complement temperature, 0.25 °C/LSB.
- temp_load_i  input  1  capture temp_i into the holding register.
- shutdown_o  output  1  1 = shutdown mode.
- frame_done_o  output  1  one-clk pulse when a 16-bit read completes.
- write_done_o  output  1  one-clk pulse when a 16-bit write completes.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; sio_o=0; sio_oe=0; shutdown_o=0; pulses=0; temp_hold=0; bit_cnt=0.
  - Synchronizer flops reset to cs=1, sck=0, sio=0.
- Synchronization: all three inputs pass through SYNC_STAGES flops.
  - Edge detection compares the last two synced samples.
  - Latency from input pin to action: SYNC_STAGES+1 clk.
- Holding register: loads temp_i when temp_load_i=1 and synced CS=1 (no transfer in progress). Loads requested while CS=0 are dropped.
- Frame word: shutdown_o=0 ? {temp_hold, TRAIL_BITS} : ID_WORD.
- States and transitions:
  - IDLE: sio_oe=0. On CS falling edge: load shift register with the frame word, sio_o=MSB, sio_oe=1, bit_cnt=0, go to READ.
  - READ:
    - Each SCK falling edge: shift left, sio_o=new MSB, bit_cnt++.
    - On the 16th SCK falling edge (bit_cnt 15→16): sio_oe=0, frame_done_o pulses, bit_cnt=0, go to WRITE.
    - SCK rising edges are ignored here; the controller samples on rising.
  - WRITE:
    - Each SCK rising edge: shift synced SIO into a 16-bit receive register (MSB first), bit_cnt++.
    - At 16 bits: write_done_o pulses and the low byte is decoded.
    - 8'hFF → shutdown_o=1; 8'h00 → shutdown_o=0; any other value → shutdown_o unchanged.
    - Then go to DONE.
  - DONE: sio_oe=0; ignore SCK until CS rises.
- CS rising edge in any state → IDLE next clk, sio_oe=0, bit_cnt=0. A partial read gives no frame_done_o; a partial write gives no write_done_o and no mode change.
- Simultaneous CS rising edge and the 16th SCK edge in the same clk: CS wins, no pulse.
- SCK edges while CS=1 are ignored.
- bit_cnt is 5 bits and never wraps inside a state; READ and WRITE each count 0..16.
- shutdown_o persists across frames; only a completed write or reset changes it.
- sio_oe is never 1 outside READ.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'b00, READ=2'b01, WRITE=2'b10, DONE=2'b11
  - FRAME_BITS=16
  - CMD_SHUTDOWN=8'hFF, CMD_CONTINUOUS=8'h00
  - default ID_WORD
- One natural sub-module, spi_in_sync: an N-stage synchronizer plus rise/fall edge detector, instantiated for cs_n_i, sck_i and sio_i.

Test Plan:
- Normal read: temp_load_i with temp_i=11'h0C8 (+50 °C), then CS low and 16 SCK cycles → controller captures 16'h191F; frame_done_o pulses once; sio_oe drops after the 16th falling edge.
- Negative temperature: temp_i=11'h7D8 (−10 °C) → frame 16'hFB1F.
- Shutdown write: read, then drive 16'h00FF in the write phase → write_done_o pulses, shutdown_o=1; the next read returns 16'h8100. Writing 16'h0000 → shutdown_o=0; the next read returns the temperature frame.
- Aborted transfer: CS rises after 7 read bits → state IDLE, no frame_done_o. Abort after 10 write bits of 16'h00FF → shutdown_o unchanged.
- Load during transfer: temp_load_i=1 with temp_i=11'h010 while CS=0 → the current frame keeps its old value; the value is captured only on a later load with CS=1.
- Reset mid-READ: rst_n low at bit 5 → sio_oe=0 and shutdown_o=0 immediately; after release with CS held low, no output until a fresh CS falling edge.
